// File: rtl/hssl_link_pkg.sv
// Shared types and constants for the HSSL link bring-up/recovery sequencer.
package hssl_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ALIGN   = 3'd1,
    ST_HSHAKE  = 3'd2,
    ST_UP      = 3'd3,
    ST_RECOVER = 3'd4,
    ST_FAIL    = 3'd5
  } link_state_t;

  localparam int DEF_ALIGN_STABLE_CYCLES = 1024;
  localparam int DEF_HS_TIMEOUT_CYCLES   = 1048576;
  localparam int DEF_BUFRST_CYCLES       = 16;
  localparam int DEF_MAX_RETRIES         = 8;

  // Bit of rxbufstatus that flags elastic buffer overflow/underflow
  localparam int RXBUF_ERR_BIT = 2;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hssl_link_timer.sv
// Loadable, clearable up-counter with a terminal-count flag.
module hssl_link_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  input  logic [WIDTH-1:0] terminal,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Count register: clear wins over load, load wins over increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == terminal);

endmodule

// File: rtl/hssl_link_controller.sv
// Link bring-up and recovery sequencer; gates the frame transmitter until the link is verified up.
module hssl_link_controller
  import hssl_link_pkg::*;
#(
  parameter int ALIGN_STABLE_CYCLES = DEF_ALIGN_STABLE_CYCLES,
  parameter int HS_TIMEOUT_CYCLES   = DEF_HS_TIMEOUT_CYCLES,
  parameter int BUFRST_CYCLES       = DEF_BUFRST_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_in,
  input  logic        rxbyteisaligned_in,
  input  logic [2:0]  rxbufstatus_in,
  input  logic        handshake_complete_in,
  input  logic        version_mismatch_in,
  output logic        rxbufreset_out,
  output logic        reg_stop_out,
  output logic        link_up_out,
  output logic        fail_out,
  output logic [2:0]  state_out,
  output logic [15:0] recoveries_out
);

  localparam int STAB_MAX = (ALIGN_STABLE_CYCLES > BUFRST_CYCLES) ? ALIGN_STABLE_CYCLES : BUFRST_CYCLES;
  localparam int STAB_W   = cnt_width(STAB_MAX);
  localparam int HS_W     = cnt_width(HS_TIMEOUT_CYCLES);
  localparam int RETRY_W  = cnt_width(MAX_RETRIES + 1);

  localparam logic [STAB_W-1:0]  ALIGN_LAST  = STAB_W'(ALIGN_STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0]  BUFRST_LAST = STAB_W'(BUFRST_CYCLES - 1);
  localparam logic [HS_W-1:0]    HS_LAST     = HS_W'(HS_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  link_state_t        state;
  link_state_t        state_next;
  logic               state_change;
  logic               aligned;
  logic               buf_err;
  logic               stab_clear;
  logic               stab_inc;
  logic [STAB_W-1:0]  stab_terminal;
  logic               stab_done;
  logic               hs_clear;
  logic               hs_inc;
  logic               hs_done;
  logic [RETRY_W-1:0] retries;
  logic [15:0]        recoveries;

  assign aligned      = rxbyteisaligned_in;
  assign buf_err      = rxbufstatus_in[RXBUF_ERR_BIT];
  assign state_change = (state_next != state);

  // One counter serves as the ALIGN stability counter and the RECOVER pulse timer
  always_comb begin
    stab_clear    = state_change || ((state == ST_ALIGN) && !aligned);
    stab_inc      = (state == ST_ALIGN) || (state == ST_RECOVER);
    stab_terminal = (state == ST_RECOVER) ? BUFRST_LAST : ALIGN_LAST;
    hs_clear      = state_change;
    hs_inc        = (state == ST_HSHAKE);
  end

  hssl_link_timer #(.WIDTH(STAB_W)) u_stab_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (stab_clear),
    .load       (1'b0),
    .load_value ('0),
    .inc        (stab_inc),
    .terminal   (stab_terminal),
    .done       (stab_done)
  );

  hssl_link_timer #(.WIDTH(HS_W)) u_hs_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (hs_clear),
    .load       (1'b0),
    .load_value ('0),
    .inc        (hs_inc),
    .terminal   (HS_LAST),
    .done       (hs_done)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: enable low beats version mismatch, which beats every recovery cause
  always_comb begin
    state_next = state;
    if (!enable_in) begin
      state_next = ST_IDLE;
    end else if (version_mismatch_in &&
                 (state == ST_ALIGN || state == ST_HSHAKE || state == ST_UP)) begin
      state_next = ST_FAIL;
    end else begin
      case (state)
        ST_IDLE:    state_next = ST_ALIGN;
        ST_ALIGN:   if (aligned && stab_done) state_next = ST_HSHAKE;
        ST_HSHAKE: begin
          if (!aligned || buf_err || (hs_done && !handshake_complete_in)) begin
            state_next = ST_RECOVER;
          end else if (handshake_complete_in) begin
            state_next = ST_UP;
          end
        end
        ST_UP:      if (!aligned || buf_err || !handshake_complete_in) state_next = ST_RECOVER;
        ST_RECOVER: if (stab_done) state_next = (retries == RETRY_LIMIT) ? ST_FAIL : ST_ALIGN;
        ST_FAIL:    state_next = ST_FAIL;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  // Retry and recovery bookkeeping on RECOVER/UP entry; dropping enable wipes both
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retries    <= '0;
      recoveries <= '0;
    end else if (!enable_in) begin
      retries    <= '0;
      recoveries <= '0;
    end else if ((state_next == ST_RECOVER) && (state != ST_RECOVER)) begin
      retries <= retries + 1'b1;
      if (recoveries != 16'hFFFF) begin
        recoveries <= recoveries + 16'd1;
      end
    end else if ((state_next == ST_UP) && (state != ST_UP)) begin
      retries <= '0;
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    reg_stop_out   = 1'b1;
    link_up_out    = 1'b0;
    rxbufreset_out = 1'b0;
    fail_out       = 1'b0;
    case (state)
      ST_UP: begin
        reg_stop_out = 1'b0;
        link_up_out  = 1'b1;
      end
      ST_RECOVER: rxbufreset_out = 1'b1;
      ST_FAIL:    fail_out       = 1'b1;
      default: ;
    endcase
  end

  assign state_out      = state;
  assign recoveries_out = recoveries;

endmodule

// File: tb/tb_hssl_link_controller.sv
// Directed, scoreboard-driven bench for the HSSL link sequencer (small parameter set).
module tb_hssl_link_controller;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ALIGN   = 3'd1;
  localparam logic [2:0] S_HSHAKE  = 3'd2;
  localparam logic [2:0] S_UP      = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;
  localparam logic [2:0] S_FAIL    = 3'd5;

  logic        clk;
  logic        reset;
  logic        enable_in;
  logic        rxbyteisaligned_in;
  logic [2:0]  rxbufstatus_in;
  logic        handshake_complete_in;
  logic        version_mismatch_in;
  logic        rxbufreset_out;
  logic        reg_stop_out;
  logic        link_up_out;
  logic        fail_out;
  logic [2:0]  state_out;
  logic [15:0] recoveries_out;

  int vectors;
  int miscompares;

  logic [22:0] exp_q[$];
  string       tag_q[$];

  hssl_link_controller #(
    .ALIGN_STABLE_CYCLES (8),
    .HS_TIMEOUT_CYCLES   (64),
    .BUFRST_CYCLES       (4),
    .MAX_RETRIES         (2)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .enable_in             (enable_in),
    .rxbyteisaligned_in    (rxbyteisaligned_in),
    .rxbufstatus_in        (rxbufstatus_in),
    .handshake_complete_in (handshake_complete_in),
    .version_mismatch_in   (version_mismatch_in),
    .rxbufreset_out        (rxbufreset_out),
    .reg_stop_out          (reg_stop_out),
    .link_up_out           (link_up_out),
    .fail_out              (fail_out),
    .state_out             (state_out),
    .recoveries_out        (recoveries_out)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected output bundle from the state table: {state, bufrst, stop, up, fail, recoveries}
  function automatic logic [22:0] model(input logic [2:0] st, input logic [15:0] rec);
    logic bufrst, stop, up, fail;
    bufrst = (st == S_RECOVER);
    stop   = (st != S_UP);
    up     = (st == S_UP);
    fail   = (st == S_FAIL);
    return {st, bufrst, stop, up, fail, rec};
  endfunction

  task automatic applyStimulus(input logic en, input logic al, input logic [2:0] bs,
                               input logic hs, input logic vm);
    enable_in             = en;
    rxbyteisaligned_in    = al;
    rxbufstatus_in        = bs;
    handshake_complete_in = hs;
    version_mismatch_in   = vm;
  endtask

  task automatic expectOutput(input string tag, input logic [2:0] st, input logic [15:0] rec);
    exp_q.push_back(model(st, rec));
    tag_q.push_back(tag);
  endtask

  task automatic checkOutput();
    logic [22:0] expected;
    logic [22:0] observed;
    string       tag;
    expected = exp_q.pop_front();
    tag      = tag_q.pop_front();
    observed = {state_out, rxbufreset_out, reg_stop_out, link_up_out, fail_out, recoveries_out};
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed state=%0d bufrst/stop/up/fail=%b rec=%0d, expected state=%0d bufrst/stop/up/fail=%b rec=%0d",
             tag, observed[22:20], observed[19:16], observed[15:0],
             expected[22:20], expected[19:16], expected[15:0]);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic stepCheck(input int n, input string tag, input logic [2:0] st, input logic [15:0] rec);
    expectOutput(tag, st, rec);
    tick(n);
    checkOutput();
  endtask

  // Directed sequence covering bring-up, timeout, glitch, mismatch, async reset, stability
  initial begin
    vectors     = 0;
    miscompares = 0;
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    expectOutput("reset_state", S_IDLE, 16'd0);
    checkOutput();
    @(negedge clk);
    reset = 1'b1;
    tick(1);
    stepCheck(1, "idle_hold", S_IDLE, 16'd0);

    // Normal bring-up
    applyStimulus(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    stepCheck(1,  "t1_align_entry",  S_ALIGN,  16'd0);
    stepCheck(7,  "t1_align_last",   S_ALIGN,  16'd0);
    stepCheck(1,  "t1_hshake_entry", S_HSHAKE, 16'd0);
    stepCheck(10, "t1_hshake_wait",  S_HSHAKE, 16'd0);
    applyStimulus(1'b1, 1'b1, 3'b000, 1'b1, 1'b0);
    stepCheck(1,  "t1_up",           S_UP,     16'd0);

    // Handshake timeout twice, then FAIL, then clear via enable
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
    stepCheck(1,  "t2_idle",          S_IDLE,    16'd0);
    applyStimulus(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    stepCheck(1,  "t2_align",         S_ALIGN,   16'd0);
    stepCheck(8,  "t2_hshake_entry",  S_HSHAKE,  16'd0);
    stepCheck(63, "t2_hshake_last",   S_HSHAKE,  16'd0);
    stepCheck(1,  "t2_recover1",      S_RECOVER, 16'd1);
    stepCheck(3,  "t2_recover1_last", S_RECOVER, 16'd1);
    stepCheck(1,  "t2_realign",       S_ALIGN,   16'd1);
    stepCheck(8,  "t2_hshake2",       S_HSHAKE,  16'd1);
    stepCheck(64, "t2_recover2",      S_RECOVER, 16'd2);
    stepCheck(3,  "t2_recover2_last", S_RECOVER, 16'd2);
    stepCheck(1,  "t2_fail",          S_FAIL,    16'd2);
    stepCheck(5,  "t2_fail_hold",     S_FAIL,    16'd2);
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
    stepCheck(1,  "t2_idle_cleared",  S_IDLE,    16'd0);

    // Single-cycle alignment glitch in UP
    applyStimulus(1'b1, 1'b1, 3'b000, 1'b1, 1'b0);
    stepCheck(1, "t3_align",         S_ALIGN,   16'd0);
    stepCheck(8, "t3_hshake",        S_HSHAKE,  16'd0);
    stepCheck(1, "t3_up",            S_UP,      16'd0);
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b1, 1'b0);
    stepCheck(1, "t3_recover",       S_RECOVER, 16'd1);
    applyStimulus(1'b1, 1'b1, 3'b000, 1'b1, 1'b0);
    stepCheck(3, "t3_recover_last",  S_RECOVER, 16'd1);
    stepCheck(1, "t3_realign",       S_ALIGN,   16'd1);
    stepCheck(7, "t3_align_restart", S_ALIGN,   16'd1);
    stepCheck(1, "t3_hshake2",       S_HSHAKE,  16'd1);
    stepCheck(1, "t3_relink",        S_UP,      16'd1);

    // Buffer error and version mismatch together in UP
    applyStimulus(1'b1, 1'b1, 3'b100, 1'b1, 1'b1);
    stepCheck(1, "t4_mismatch_fail", S_FAIL, 16'd1);
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b1, 1'b0);
    stepCheck(1, "t4_idle",          S_IDLE, 16'd0);

    // Asynchronous reset in the middle of RECOVER
    applyStimulus(1'b1, 1'b1, 3'b000, 1'b1, 1'b0);
    stepCheck(1, "t5_align",       S_ALIGN,   16'd0);
    stepCheck(8, "t5_hshake",      S_HSHAKE,  16'd0);
    stepCheck(1, "t5_up",          S_UP,      16'd0);
    applyStimulus(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    stepCheck(1, "t5_recover",     S_RECOVER, 16'd1);
    stepCheck(1, "t5_recover_mid", S_RECOVER, 16'd1);
    expectOutput("t5_async_reset", S_IDLE, 16'd0);
    #2 reset = 1'b0;
    #1 checkOutput();
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick(1);
    stepCheck(1, "t5_post_reset", S_IDLE, 16'd0);

    // Alignment drops every 5th cycle: never stable long enough
    applyStimulus(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    stepCheck(1, "t6_align", S_ALIGN, 16'd0);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, ((i % 5) != 4), 3'b000, 1'b0, 1'b0);
      if ((i % 10) == 9) begin
        stepCheck(1, "t6_align_hold", S_ALIGN, 16'd0);
      end else begin
        tick(1);
      end
    end
    applyStimulus(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    stepCheck(7, "t6_stable_last", S_ALIGN,  16'd0);
    stepCheck(1, "t6_hshake",      S_HSHAKE, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
